// File: rtl/l15_core_transducer.sv
// Single-outstanding core-to-L1.5 request transducer with one-cycle core response.
// Optional WAIT watchdog enabled by defining L15_CORE_TRANSDUCER_TIMEOUT_EN.
module l15_core_transducer #(
   parameter int unsigned THREADID       = 0,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        core_req_val,
   output logic        core_req_rdy,
   input  logic        core_req_we,
   input  logic [39:0] core_req_addr,
   input  logic [2:0]  core_req_size,
   input  logic        core_req_nc,
   input  logic [63:0] core_req_wdata,
   output logic        core_resp_val,
   output logic [63:0] core_resp_rdata,
   output logic [1:0]  core_resp_err,

   output logic        transducer_l15_val,
   output logic [4:0]  transducer_l15_rqtype,
   output logic [39:0] transducer_l15_address,
   output logic [2:0]  transducer_l15_size,
   output logic        transducer_l15_nc,
   output logic [63:0] transducer_l15_data,
   output logic [0:0]  transducer_l15_threadid,
   output logic        transducer_l15_data_next_entry,
   output logic        transducer_l15_prefetch,
   output logic        transducer_l15_invalidate_cacheline,
   output logic        transducer_l15_blockstore,
   output logic        transducer_l15_blockinitstore,
   output logic [1:0]  transducer_l15_l1rplway,
   output logic [3:0]  transducer_l15_amo_op,
   output logic [3:0]  transducer_l15_cmo_op,
   output logic [32:0] transducer_l15_csm_data,

   input  logic        l15_transducer_ack,
   input  logic        l15_transducer_header_ack,
   input  logic        l15_transducer_val,
   input  logic [3:0]  l15_transducer_returntype,
   input  logic [1:0]  l15_transducer_error,
   input  logic [63:0] l15_transducer_data_0,
   input  logic [63:0] l15_transducer_data_1,
   output logic        transducer_l15_req_ack
);

   localparam logic [3:0] LoadRet = 4'b0000;
   localparam logic [3:0] StAck   = 4'b0100;

   typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

   state_e      state_q, state_d;
   logic        we_q, we_d;
   logic [39:0] addr_q, addr_d;
   logic [2:0]  size_q, size_d;
   logic        nc_q, nc_d;
   logic [63:0] data_q, data_d;
   logic [63:0] rdata_q, rdata_d;
   logic [1:0]  err_q, err_d;
   logic        match;
   logic        capture;
   logic        unused_ok;

`ifdef L15_CORE_TRANSDUCER_TIMEOUT_EN
   logic [15:0] wdog_q, wdog_d;
   logic        expire;
`endif

   // Single-flit requests: header_ack alone carries no information here.
   assign unused_ok = l15_transducer_header_ack ^ (TIMEOUT_CYCLES == 0);

   assign match = l15_transducer_val &&
                  (l15_transducer_returntype == (we_q ? StAck : LoadRet));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         we_q    <= 1'b0;
         addr_q  <= '0;
         size_q  <= '0;
         nc_q    <= 1'b0;
         data_q  <= '0;
         rdata_q <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         nc_q    <= nc_d;
         data_q  <= data_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

`ifdef L15_CORE_TRANSDUCER_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) wdog_q <= '0;
      else     wdog_q <= wdog_d;
   end

   always_comb begin
      wdog_d = wdog_q;
      if (state_q == StReq && l15_transducer_ack) wdog_d = '0;
      else if (state_q == StWait)                 wdog_d = wdog_q + 16'd1;
   end

   assign expire = (wdog_q == 16'(TIMEOUT_CYCLES - 1));
`endif

   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      unique case (state_q)
         StIdle: if (core_req_val) state_d = StReq;
         StReq: begin
            if (l15_transducer_ack) begin
               state_d = match ? StResp : StWait;
               capture = match;
            end
         end
         StWait: begin
            if (match) begin
               state_d = StResp;
               capture = 1'b1;
            end
`ifdef L15_CORE_TRANSDUCER_TIMEOUT_EN
            else if (expire) state_d = StResp;
`endif
         end
         StResp: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Request capture, with store data replicated across the 8-byte lane.
   always_comb begin
      we_d   = we_q;
      addr_d = addr_q;
      size_d = size_q;
      nc_d   = nc_q;
      data_d = data_q;
      if (state_q == StIdle && core_req_val) begin
         we_d   = core_req_we;
         addr_d = core_req_addr;
         size_d = core_req_size;
         nc_d   = core_req_nc;
         case (core_req_size)
            3'd0:    data_d = {8{core_req_wdata[7:0]}};
            3'd1:    data_d = {4{core_req_wdata[15:0]}};
            3'd2:    data_d = {2{core_req_wdata[31:0]}};
            default: data_d = core_req_wdata;
         endcase
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      err_d   = err_q;
      if (capture) begin
         err_d = l15_transducer_error;
         if (we_q)           rdata_d = '0;
         else if (addr_q[3]) rdata_d = l15_transducer_data_1;
         else                rdata_d = l15_transducer_data_0;
      end
`ifdef L15_CORE_TRANSDUCER_TIMEOUT_EN
      else if (state_q == StWait && expire) begin
         rdata_d = '0;
         err_d   = 2'b11;
      end
`endif
   end

   assign core_req_rdy    = (state_q == StIdle);
   assign core_resp_val   = (state_q == StResp);
   assign core_resp_rdata = rdata_q;
   assign core_resp_err   = err_q;

   assign transducer_l15_val      = (state_q == StReq);
   assign transducer_l15_rqtype   = {4'b0000, we_q};
   assign transducer_l15_address  = addr_q;
   assign transducer_l15_size     = size_q;
   assign transducer_l15_nc       = nc_q;
   assign transducer_l15_data     = data_q;
   assign transducer_l15_threadid = 1'(THREADID);

   assign transducer_l15_data_next_entry      = 1'b0;
   assign transducer_l15_prefetch             = 1'b0;
   assign transducer_l15_invalidate_cacheline = 1'b0;
   assign transducer_l15_blockstore           = 1'b0;
   assign transducer_l15_blockinitstore       = 1'b0;
   assign transducer_l15_l1rplway             = '0;
   assign transducer_l15_amo_op               = '0;
   assign transducer_l15_cmo_op               = '0;
   assign transducer_l15_csm_data             = '0;

   // Every return is consumed immediately, matching or not.
   assign transducer_l15_req_ack = l15_transducer_val;

endmodule
